mips_mc_ctrl: RTL and testbench

//  Multicycle control FSM for the MIPS datapath (reg file, ALU, unified instr/data memory).

---
 rtl/mips_mc_pkg.sv | 68 ++++++
 rtl/mips_alu_dec.sv | 41 ++++
 rtl/mips_mc_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_mips_mc_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: state enum, opcode and
// funct values, ALU operation classes, ALU control codes and the control bundle.
package mips_mc_pkg;

    // Twelve FSM states; encodings 12..15 are unused and recover to FETCH.
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_e;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // What the ALU is asked to do in a given state
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'd0,
        ALUOP_SUB   = 2'd1,
        ALUOP_FUNCT = 2'd2
    } aluop_e;

    // ALU control codes seen by the datapath
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Every datapath control in one bundle so reset gating is a single assignment
    typedef struct packed {
        logic       pcwrite;
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [2:0] alucontrol;
        logic       illegal_op;
        logic       instr_done;
    } ctrl_t;

endpackage

// File: rtl/mips_alu_dec.sv
// ALU decoder: maps the state's ALU operation class and the R-type funct field
// to the 3-bit ALU control code, and flags whether funct is a supported R-type op.
module mips_alu_dec
    import mips_mc_pkg::*;
(
    input  aluop_e     aluop_i,
    input  logic [5:0] funct_i,
    output logic [2:0] alucontrol_o,
    output logic       funct_legal_o
);

    // Legality depends on funct alone, kept apart so DECODE can use it without
    // creating a combinational path back through aluop.
    always_comb begin
        unique case (funct_i)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: funct_legal_o = 1'b1;
            default:                               funct_legal_o = 1'b0;
        endcase
    end

    // Select the ALU code from the operation class, consulting funct for R-types
    always_comb begin
        alucontrol_o = ALU_ADD;
        case (aluop_i)
            ALUOP_ADD: alucontrol_o = ALU_ADD;
            ALUOP_SUB: alucontrol_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct_i)
                    FN_ADD:  alucontrol_o = ALU_ADD;
                    FN_SUB:  alucontrol_o = ALU_SUB;
                    FN_AND:  alucontrol_o = ALU_AND;
                    FN_OR:   alucontrol_o = ALU_OR;
                    FN_SLT:  alucontrol_o = ALU_SLT;
                    default: alucontrol_o = ALU_ADD;
                endcase
            end
            default: alucontrol_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control FSM. Sequences fetch/decode/execute/memory/writeback,
// stalls FETCH/MEMRD/MEMWR on mem_ready, and keeps a sticky illegal-op flag.
// Optional feature: define MIPS_MC_BNE_EN to decode bne (op 000101) as a branch
// taken on ~zero; without it bne is treated as an illegal opcode.
module mips_mc_ctrl
    import mips_mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pcwrite,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       illegal_op,
    output logic       instr_done
);

    state_e     state_q, state_d;
    logic       illegal_q, illegal_d;
    aluop_e     aluop;
    logic       alu_used;
    logic [2:0] alucontrol_dec;
    logic       funct_legal;
    logic       branch_taken;
    ctrl_t      ctrl_base;
    ctrl_t      ctrl_out;

    mips_alu_dec u_alu_dec (
        .aluop_i       (aluop),
        .funct_i       (funct),
        .alucontrol_o  (alucontrol_dec),
        .funct_legal_o (funct_legal)
    );

    // Branch condition: beq on zero, bne (when enabled) on not-zero
`ifdef MIPS_MC_BNE_EN
    assign branch_taken = (op == OP_BNE) ? ~zero : zero;
`else
    assign branch_taken = zero;
`endif

    // State and sticky illegal flag; synchronous reset returns to FETCH
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples
        // pre-edge values regardless of statement order.
        if (reset) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state and Moore controls, with mem_ready/zero qualifying the few live bits
    always_comb begin
        // NOTE: every output of this block gets a default first so no path through
        // the case statement can leave one unassigned and infer a latch.
        ctrl_base = '0;
        state_d   = S_FETCH;
        illegal_d = illegal_q;
        aluop     = ALUOP_ADD;
        alu_used  = 1'b0;

        case (state_q)
            S_FETCH: begin
                ctrl_base.alusrcb = 2'b01;
                alu_used          = 1'b1;
                ctrl_base.irwrite = mem_ready;
                ctrl_base.pcwrite = mem_ready;
                state_d           = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ctrl_base.alusrcb = 2'b11;
                alu_used          = 1'b1;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE: begin
                        if (funct_legal) begin
                            state_d = S_EXECUTE;
                        end else begin
                            state_d   = S_FETCH;
                            illegal_d = 1'b1;
                        end
                    end
                    OP_BEQ:  state_d = S_BRANCH;
`ifdef MIPS_MC_BNE_EN
                    OP_BNE:  state_d = S_BRANCH;
`endif
                    OP_ADDI: state_d = S_ADDIEXEC;
                    OP_J:    state_d = S_JUMP;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ctrl_base.alusrca = 1'b1;
                ctrl_base.alusrcb = 2'b10;
                alu_used          = 1'b1;
                state_d           = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                ctrl_base.iord = 1'b1;
                state_d        = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                ctrl_base.memtoreg   = 1'b1;
                ctrl_base.regwrite   = 1'b1;
                ctrl_base.instr_done = 1'b1;
            end
            S_MEMWR: begin
                ctrl_base.iord       = 1'b1;
                ctrl_base.memwrite   = 1'b1;
                ctrl_base.instr_done = mem_ready;
                state_d              = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXECUTE: begin
                ctrl_base.alusrca = 1'b1;
                aluop             = ALUOP_FUNCT;
                alu_used          = 1'b1;
                state_d           = S_ALUWB;
            end
            S_ALUWB: begin
                ctrl_base.regdst     = 1'b1;
                ctrl_base.regwrite   = 1'b1;
                ctrl_base.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl_base.alusrca    = 1'b1;
                ctrl_base.pcsrc      = 2'b01;
                ctrl_base.pcwrite    = branch_taken;
                ctrl_base.instr_done = 1'b1;
                aluop                = ALUOP_SUB;
                alu_used             = 1'b1;
            end
            S_ADDIEXEC: begin
                ctrl_base.alusrca = 1'b1;
                ctrl_base.alusrcb = 2'b10;
                alu_used          = 1'b1;
                state_d           = S_ADDIWB;
            end
            S_ADDIWB: begin
                ctrl_base.regwrite   = 1'b1;
                ctrl_base.instr_done = 1'b1;
            end
            S_JUMP: begin
                ctrl_base.pcsrc      = 2'b10;
                ctrl_base.pcwrite    = 1'b1;
                ctrl_base.instr_done = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Merge in ALU code and sticky flag, then hold everything at 0 during reset
    always_comb begin
        ctrl_out            = ctrl_base;
        ctrl_out.alucontrol = alu_used ? alucontrol_dec : 3'b000;
        ctrl_out.illegal_op = illegal_q;
        if (reset) begin
            ctrl_out = '0;
        end
    end

    assign pcwrite    = ctrl_out.pcwrite;
    assign iord       = ctrl_out.iord;
    assign memwrite   = ctrl_out.memwrite;
    assign irwrite    = ctrl_out.irwrite;
    assign regdst     = ctrl_out.regdst;
    assign memtoreg   = ctrl_out.memtoreg;
    assign regwrite   = ctrl_out.regwrite;
    assign alusrca    = ctrl_out.alusrca;
    assign alusrcb    = ctrl_out.alusrcb;
    assign pcsrc      = ctrl_out.pcsrc;
    assign alucontrol = ctrl_out.alucontrol;
    assign illegal_op = ctrl_out.illegal_op;
    assign instr_done = ctrl_out.instr_done;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Self-checking bench for mips_mc_ctrl. Expected outputs come from an
// instruction-level model: each instruction is a numbered list of steps whose
// controls follow from what that step of the instruction has to accomplish.
module tb_mips_mc_ctrl;

    typedef struct packed {
        logic       pcwrite;
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [2:0] alucontrol;
        logic       illegal_op;
        logic       instr_done;
    } outs_t;

    typedef enum int {C_LW, C_SW, C_R, C_ADDI, C_BEQ, C_BNE, C_J, C_ILL} cls_e;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pcwrite, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic       illegal_op, instr_done;

    int    total = 0;
    int    bad = 0;
    int    done_cnt = 0;
    int    mw_cnt = 0;
    bit    exp_valid = 1'b0;
    bit    ill_model = 1'b0;
    outs_t exp_q;
    outs_t hist[$];

    mips_mc_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pcwrite    (pcwrite),
        .iord       (iord),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .regwrite   (regwrite),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .alucontrol (alucontrol),
        .illegal_op (illegal_op),
        .instr_done (instr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic bit funct_ok(input logic [5:0] fn);
        return fn == 6'b100000 || fn == 6'b100010 || fn == 6'b100100 ||
               fn == 6'b100101 || fn == 6'b101010;
    endfunction

    function automatic logic [2:0] alu_of(input logic [5:0] fn);
        case (fn)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            default:   return 3'b111;
        endcase
    endfunction

    function automatic cls_e classify(input logic [5:0] o, input logic [5:0] fn);
        case (o)
            6'b100011: return C_LW;
            6'b101011: return C_SW;
            6'b000000: return funct_ok(fn) ? C_R : C_ILL;
            6'b000100: return C_BEQ;
            6'b001000: return C_ADDI;
            6'b000010: return C_J;
`ifdef MIPS_MC_BNE_EN
            6'b000101: return C_BNE;
`endif
            default:   return C_ILL;
        endcase
    endfunction

    // Cycles per instruction when memory is always ready
    function automatic int nsteps(input cls_e c);
        case (c)
            C_LW:                return 5;
            C_SW, C_R, C_ADDI:   return 4;
            C_BEQ, C_BNE, C_J:   return 3;
            default:             return 2;
        endcase
    endfunction

    // Steps that wait for the memory to finish an access
    function automatic bit mem_step(input cls_e c, input int step);
        return step == 0 || (step == 3 && (c == C_LW || c == C_SW));
    endfunction

    function automatic outs_t model(input cls_e c, input int step, input bit rdy,
                                    input bit zr, input logic [5:0] fn, input bit ill);
        outs_t o = '0;
        o.illegal_op = ill;
        if (step == 0) begin          // fetch: read mem[PC], PC+4
            o.alusrcb = 2'b01; o.alucontrol = 3'b010;
            o.irwrite = rdy;   o.pcwrite = rdy;
        end else if (step == 1) begin // decode: PC + (imm<<2)
            o.alusrcb = 2'b11; o.alucontrol = 3'b010;
        end else begin
            case (c)
                C_LW, C_SW: begin
                    if (step == 2) begin
                        o.alusrca = 1; o.alusrcb = 2'b10; o.alucontrol = 3'b010;
                    end else if (c == C_LW && step == 3) begin
                        o.iord = 1;
                    end else if (c == C_LW) begin
                        o.memtoreg = 1; o.regwrite = 1; o.instr_done = 1;
                    end else begin
                        o.iord = 1; o.memwrite = 1; o.instr_done = rdy;
                    end
                end
                C_R: begin
                    if (step == 2) begin
                        o.alusrca = 1; o.alucontrol = alu_of(fn);
                    end else begin
                        o.regdst = 1; o.regwrite = 1; o.instr_done = 1;
                    end
                end
                C_ADDI: begin
                    if (step == 2) begin
                        o.alusrca = 1; o.alusrcb = 2'b10; o.alucontrol = 3'b010;
                    end else begin
                        o.regwrite = 1; o.instr_done = 1;
                    end
                end
                C_BEQ, C_BNE: begin
                    o.alusrca = 1; o.alucontrol = 3'b110; o.pcsrc = 2'b01;
                    o.pcwrite = (c == C_BEQ) ? zr : ~zr;
                    o.instr_done = 1;
                end
                C_J: begin
                    o.pcsrc = 2'b10; o.pcwrite = 1; o.instr_done = 1;
                end
                default: ;
            endcase
        end
        return o;
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        outs_t act;
        if (exp_valid) begin
            act = {pcwrite, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                   alusrcb, pcsrc, alucontrol, illegal_op, instr_done};
            check("outputs", 32'(act), 32'(exp_q));
            hist.push_back(act);
            if (act.instr_done) done_cnt++;
            if (act.memwrite) mw_cnt++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic cycle(input bit rdy, input bit zr, input bit rst,
                         input logic [5:0] op_v, input logic [5:0] fn, input outs_t e);
        @(posedge clk);
        #1;
        reset = rst; mem_ready = rdy; zero = zr; op = op_v; funct = fn;
        exp_q = e; exp_valid = 1'b1;
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [5:0] op_v, input logic [5:0] fn);
        cycle(1'($urandom), 1'($urandom), 1'b1, op_v, fn, '0);
        ill_model = 1'b0;
    endtask

    function automatic bit pick_zero(input int zmode);
        return (zmode < 0) ? 1'($urandom) : zmode[0];
    endfunction

    // Runs one instruction; abort_step >= 0 asserts reset during that step instead
    // of completing it.
    task automatic run_instr(input logic [5:0] op_v, input logic [5:0] fn,
                             input int fstall, input int mstall, input int zmode,
                             input int abort_step, output int ncyc);
        cls_e c = classify(op_v, fn);
        bit   zr, rdy;
        int   stalls;
        ncyc = 0;
        for (int step = 0; step < nsteps(c); step++) begin
            stalls = mem_step(c, step) ? ((step == 0) ? fstall : mstall) : 0;
            for (int k = 0; k < stalls; k++) begin
                zr = pick_zero(zmode);
                cycle(1'b0, zr, 1'b0, op_v, fn, model(c, step, 1'b0, zr, fn, ill_model));
                ncyc++;
            end
            if (step == abort_step) begin
                do_reset(op_v, fn);
                return;
            end
            rdy = mem_step(c, step) ? 1'b1 : 1'($urandom);
            zr  = pick_zero(zmode);
            cycle(rdy, zr, 1'b0, op_v, fn, model(c, step, rdy, zr, fn, ill_model));
            ncyc++;
            if (c == C_ILL && step == 1) ill_model = 1'b1;
        end
    endtask

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000,
                           BEQ = 6'b000100, BNE = 6'b000101, ADDI = 6'b001000,
                           JMP = 6'b000010;

    initial begin
        int n;
        int cnt;
        logic [5:0] rop, rfn;
        reset = 1'b1; op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;

        // Reset state: all outputs 0
        do_reset(RT, 6'd0);
        do_reset(RT, 6'd0);

        // Reset in the middle of a load's memory read, then the next fetch
        run_instr(LW, 6'd0, 0, 2, -1, 3, n);
        hist.delete();
        run_instr(JMP, 6'd0, 0, 0, -1, -1, n);
        check("after_reset_irwrite", 32'(hist[0].irwrite), 32'd1);

        // lw with memory always ready
        hist.delete(); done_cnt = 0;
        run_instr(LW, 6'd0, 0, 0, -1, -1, n);
        check("lw_cycles", n, 5);
        check("lw_done_pulses", done_cnt, 1);
        check("lw_wb_regwrite", 32'({hist[4].regwrite, hist[4].memtoreg}), 32'b11);
        cnt = 0;
        for (int i = 0; i < 4; i++) cnt += hist[i].regwrite + hist[i].memtoreg;
        check("lw_no_early_write", cnt, 0);

        // sw with three not-ready cycles in the write state
        mw_cnt = 0;
        run_instr(SW, 6'd0, 0, 3, -1, -1, n);
        check("sw_memwrite_cycles", mw_cnt, 4);
        check("sw_cycles", n, 7);

        // beq taken and not taken
        hist.delete();
        run_instr(BEQ, 6'd0, 0, 0, 1, -1, n);
        check("beq_taken", 32'({hist[2].pcwrite, hist[2].pcsrc}), 32'b101);
        hist.delete();
        run_instr(BEQ, 6'd0, 1, 0, 0, -1, n);
        check("beq_not_taken", 32'(hist[3].pcwrite), 32'd0);

        // slt, then an illegal funct that must stick through a legal addi
        hist.delete();
        run_instr(RT, 6'b101010, 0, 0, -1, -1, n);
        check("slt_alucontrol", 32'(hist[2].alucontrol), 32'b111);
        check("slt_wb", 32'({hist[3].regdst, hist[3].regwrite}), 32'b11);
        run_instr(RT, 6'b000111, 0, 0, -1, -1, n);
        hist.delete();
        run_instr(ADDI, 6'd0, 0, 0, -1, -1, n);
        check("illegal_set", 32'(hist[0].illegal_op), 32'd1);
        check("illegal_sticky", 32'(illegal_op), 32'd1);

        // bne: branch when enabled, illegal otherwise
        do_reset(RT, 6'd0);
        hist.delete();
        run_instr(BNE, 6'd0, 0, 0, 0, -1, n);
        run_instr(JMP, 6'd0, 0, 0, -1, -1, n);
`ifdef MIPS_MC_BNE_EN
        check("bne_taken", 32'(hist[2].pcwrite), 32'd1);
        check("bne_legal", 32'(hist[3].illegal_op), 32'd0);
`else
        check("bne_illegal", 32'(hist[2].illegal_op), 32'd1);
`endif

        // Random instruction stream with stalls and occasional aborts
        for (int i = 0; i < 250; i++) begin
            case ($urandom_range(0, 8))
                0: rop = LW;
                1: rop = SW;
                2, 3: rop = RT;
                4: rop = ADDI;
                5: rop = BEQ;
                6: rop = BNE;
                7: rop = JMP;
                default: rop = 6'($urandom);
            endcase
            rfn = 6'($urandom);
            if (rop == RT && $urandom_range(0, 3) != 0) begin
                case ($urandom_range(0, 4))
                    0: rfn = 6'b100000;
                    1: rfn = 6'b100010;
                    2: rfn = 6'b100100;
                    3: rfn = 6'b100101;
                    default: rfn = 6'b101010;
                endcase
            end
            run_instr(rop, rfn,
                      ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3),
                      ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3),
                      -1,
                      ($urandom_range(0, 24) == 0) ? $urandom_range(0, 4) : -1, n);
        end

        exp_valid = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
